imem_readback: RTL and testbench

//  Reads back a contiguous range of CPU instruction memory, the counterpart of the initialize write path.

---
 rtl/imem_rb_pkg.sv | 14 +
 rtl/imem_readback_skid_buf.sv | 50 +++++
 rtl/imem_readback.sv | 153 +++++++++++++++
 tb/tb_imem_readback.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_rb_pkg.sv
// imem_rb_pkg: shared FSM encoding and buffer sizing for the instruction-memory readback block.
package imem_rb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam int ADDR_STEP = 4;
  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/imem_readback_skid_buf.sv
// rb_skid_buf: 2-entry FIFO carrying {addr, last, data} beats from the memory port to the stream output.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: the producer must respect count; push and pop together on a full buffer is legal.
module rb_skid_buf
  import imem_rb_pkg::*;
#(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic [1:0]   count,
  output logic         pop_vld
);

  logic [W-1:0] mem [BUF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;

  assign pop_dat = mem[rd_ptr];
  assign pop_vld = (count != 2'd0);

  // Storage is reset too so the payload outputs read zero while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imem_readback.sv
// imem_readback: streams a word range of instruction memory with byte addresses; IMEM_RB_CHECKSUM_EN adds an XOR checksum port.
// Latency: start -> first read 1 cycle, first beat 3 cycles, done pulse N+3 cycles when never stalled.
// Backpressure: out_ready low holds the beat; reads stall on credit so the 2-entry buffer never overflows.
module imem_readback
  import imem_rb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef IMEM_RB_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int ENT_W = ADDR_W + 1 + DATA_W;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  remaining;
  logic              inflight;
  logic              inflight_last;
  logic [ADDR_W-1:0] inflight_addr;
  logic [ENT_W-1:0]  push_dat;
  logic [ENT_W-1:0]  head_dat;
  logic [1:0]        buf_count;
  logic              buf_vld;
  logic              pop;
  logic              rd_go;
  logic              credit_ok;
  logic [2:0]        occ;
  logic              accept;

  assign accept = (state == IDLE) && start;
  assign pop    = buf_vld && out_ready;

  // A beat leaving this cycle frees its slot for a read issued in the same cycle.
  assign occ       = {1'b0, buf_count} + {2'b00, inflight};
  assign credit_ok = (occ - {2'b00, pop}) < 3'(BUF_DEPTH);

  always_comb begin
    state_nxt = state;
    rd_go     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (word_count != '0) ? READ : DONE;
        end
      end
      READ: begin
        rd_go = credit_ok;
        if (credit_ok && (remaining == CNT_W'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as the final beat is being taken so done lands right after it.
        if (!inflight && ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rd_addr       <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      inflight_addr <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_go;
      if (accept) begin
        rd_addr   <= base_addr & ~ADDR_W'(3);
        remaining <= word_count;
      end else if (rd_go) begin
        rd_addr   <= rd_addr + ADDR_W'(ADDR_STEP);
        remaining <= remaining - CNT_W'(1);
      end
      if (rd_go) begin
        inflight_addr <= rd_addr;
        inflight_last <= (remaining == CNT_W'(1));
      end
    end
  end

  assign push_dat = {inflight_addr, inflight_last, mem_rd_data};

  rb_skid_buf #(
    .W (ENT_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (head_dat),
    .count    (buf_count),
    .pop_vld  (buf_vld)
  );

  assign mem_rd_en   = rd_go;
  assign mem_rd_addr = rd_addr;
  assign out_valid   = buf_vld;
  assign out_data    = head_dat[DATA_W-1:0];
  assign out_last    = head_dat[DATA_W];
  assign out_addr    = head_dat[ENT_W-1 -: ADDR_W];
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

`ifdef IMEM_RB_CHECKSUM_EN
  logic [DATA_W-1:0] cs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q <= '0;
    end else if (accept) begin
      cs_q <= '0;
    end else if (pop) begin
      cs_q <= cs_q ^ out_data;
    end
  end

  assign checksum = cs_q;
`endif

endmodule

// File: tb/tb_imem_readback.sv
// tb_imem_readback: randomized scenarios checked against a range model (addr = base + 4*i, data = memory image).
module tb_imem_readback;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data = 32'h0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef IMEM_RB_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  imem_readback #(
    .ADDR_W (32),
    .DATA_W (32),
    .CNT_W  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
`ifdef IMEM_RB_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory image: explicit preloads, otherwise an address-derived pattern.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
    return (base & 32'hFFFF_FFFC) + 32'(4 * i);
  endfunction

  function automatic logic [31:0] exp_xor(input logic [31:0] base, input int n);
    logic [31:0] x = 32'h0;
    for (int i = 0; i < n; i++) x ^= mem_word(exp_addr(base, i));
    return x;
  endfunction

  function automatic logic [99:0] outs_vec();
    return {mem_rd_en, mem_rd_addr, out_valid, out_data, out_addr, out_last, busy, done};
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr);
  end

  // Observations recorded by run_xfer, judged by each test.
  logic [31:0] got_addr [$];
  logic [31:0] got_data [$];
  logic        got_last [$];
  int          got_cyc  [$];
  int          done_cyc, done_cnt, busy_cyc, rd_cnt, first_rd_cyc, max_occ, stall_err, vld_cyc;
  logic [31:0] cs_at_done;

  // mode 0: ready always 1; 1: ready toggles, stray starts; 2: random ready, stray starts.
  task automatic run_xfer(input logic [31:0] base, input logic [15:0] n, input int mode);
    int          pending;
    int          occ;
    logic        pv, pr, pl;
    logic [31:0] pd, pa;
    got_addr.delete(); got_data.delete(); got_last.delete(); got_cyc.delete();
    done_cyc = -1; done_cnt = 0; busy_cyc = 0; rd_cnt = 0; first_rd_cyc = -1;
    max_occ = 0; stall_err = 0; vld_cyc = 0; cs_at_done = 32'h0;
    pending = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 32'h0; pa = 32'h0;
    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = n; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = $urandom; word_count = 16'($urandom);
    for (int cyc = 1; cyc < 4 * int'(n) + 40 && done_cnt == 0; cyc++) begin
      if (cyc > 1) @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2) == 1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode != 0) begin
        start = 1'($urandom_range(0, 1)); base_addr = $urandom; word_count = 16'($urandom);
      end
      #1;
      if (pv && !pr && (!out_valid || out_data !== pd || out_addr !== pa || out_last !== pl))
        stall_err++;
      occ = pending + int'(mem_rd_en) - int'(out_valid && out_ready);
      if (occ > max_occ) max_occ = occ;
      pending = occ;
      if (mem_rd_en) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (out_valid) vld_cyc++;
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr); got_data.push_back(out_data);
        got_last.push_back(out_last); got_cyc.push_back(cyc);
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++; done_cyc = cyc;
`ifdef IMEM_RB_CHECKSUM_EN
        cs_at_done = checksum;
`endif
      end
      pv = out_valid; pr = out_ready; pd = out_data; pa = out_addr; pl = out_last;
    end
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done) done_cnt++;
      if (busy) busy_cyc++;
      if (out_valid) vld_cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = 32'h0; word_count = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (outs_vec() !== 100'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", outs_vec());
    end
`ifdef IMEM_RB_CHECKSUM_EN
    checks++;
    if (checksum !== 32'h0) begin
      errors++;
      $display("FAIL reset_checksum: got %h required 0", checksum);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    mem[32'h0] = 32'h0020_082A; mem[32'h4] = 32'h2022_0008; mem[32'h8] = 32'h0800_0004;
    run_xfer(32'h0, 16'd3, 0);
    checks++;
    if (got_addr.size() != 3) begin
      errors++;
      $display("FAIL basic_beats: got %0d required 3", got_addr.size());
    end
    for (int i = 0; i < got_addr.size() && i < 3; i++) begin
      checks++;
      if (got_addr[i] !== exp_addr(0, i) || got_data[i] !== mem_word(exp_addr(0, i)) || got_last[i] !== (i == 2)) begin
        errors++;
        $display("FAIL basic_beat%0d: got a=%h d=%h l=%b required a=%h d=%h l=%b", i, got_addr[i], got_data[i],
                 got_last[i], exp_addr(0, i), mem_word(exp_addr(0, i)), i == 2);
      end
      checks++;
      if (got_cyc[i] !== 3 + i) begin
        errors++;
        $display("FAIL basic_beat%0d_cycle: got %0d required %0d", i, got_cyc[i], 3 + i);
      end
    end
    checks++;
    if (first_rd_cyc !== 1) begin
      errors++;
      $display("FAIL basic_first_read: got %0d required 1", first_rd_cyc);
    end
    checks++;
    if (done_cyc !== 6 || done_cnt !== 1) begin
      errors++;
      $display("FAIL basic_done: got cycle %0d x%0d required cycle 6 x1", done_cyc, done_cnt);
    end
    checks++;
    if (busy_cyc !== 6) begin
      errors++;
      $display("FAIL basic_busy: got %0d cycles required 6", busy_cyc);
    end
`ifdef IMEM_RB_CHECKSUM_EN
    // 0x0020082A ^ 0x20220008 ^ 0x08000004 works out to 0x28020826.
    checks++;
    if (cs_at_done !== (32'h0020_082A ^ 32'h2022_0008 ^ 32'h0800_0004)) begin
      errors++;
      $display("FAIL basic_checksum: got %h required %h", cs_at_done, 32'h0020_082A ^ 32'h2022_0008 ^ 32'h0800_0004);
    end
`endif
  endtask

  task automatic test_zero_count();
    run_xfer(32'h40, 16'd0, 0);
    checks++;
    if (rd_cnt !== 0 || vld_cyc !== 0) begin
      errors++;
      $display("FAIL zero_no_traffic: got reads=%0d valid=%0d required 0/0", rd_cnt, vld_cyc);
    end
    checks++;
    if (busy_cyc !== 1) begin
      errors++;
      $display("FAIL zero_busy: got %0d cycles required 1", busy_cyc);
    end
    checks++;
    if (done_cyc !== 1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL zero_done: got cycle %0d x%0d required cycle 1 x1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_toggle_ready();
    logic [31:0] b;
    b = $urandom & 32'h0000_FFFC;
    run_xfer(b, 16'd8, 1);
    checks++;
    if (got_addr.size() != 8) begin
      errors++;
      $display("FAIL toggle_beats: got %0d required 8", got_addr.size());
    end
    for (int i = 0; i < got_addr.size() && i < 8; i++) begin
      checks++;
      if (got_addr[i] !== exp_addr(b, i) || got_data[i] !== mem_word(exp_addr(b, i)) || got_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL toggle_beat%0d: got a=%h d=%h l=%b required a=%h d=%h l=%b", i, got_addr[i], got_data[i],
                 got_last[i], exp_addr(b, i), mem_word(exp_addr(b, i)), i == 7);
      end
    end
    checks++;
    if (max_occ > 2) begin
      errors++;
      $display("FAIL toggle_occupancy: got %0d required <=2", max_occ);
    end
    checks++;
    if (stall_err !== 0) begin
      errors++;
      $display("FAIL toggle_stable: got %0d payload changes required 0", stall_err);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL toggle_done: got %0d pulses required 1", done_cnt);
    end
  endtask

  task automatic test_wrap();
    run_xfer(32'hFFFF_FFF8, 16'd4, 0);
    checks++;
    if (got_addr.size() != 4) begin
      errors++;
      $display("FAIL wrap_beats: got %0d required 4", got_addr.size());
    end
    for (int i = 0; i < got_addr.size() && i < 4; i++) begin
      checks++;
      if (got_addr[i] !== exp_addr(32'hFFFF_FFF8, i) || got_data[i] !== mem_word(exp_addr(32'hFFFF_FFF8, i))) begin
        errors++;
        $display("FAIL wrap_beat%0d: got a=%h d=%h required a=%h d=%h", i, got_addr[i], got_data[i],
                 exp_addr(32'hFFFF_FFF8, i), mem_word(exp_addr(32'hFFFF_FFF8, i)));
      end
    end
    checks++;
    if (done_cyc !== 7) begin
      errors++;
      $display("FAIL wrap_done: got cycle %0d required 7", done_cyc);
    end
  endtask

  task automatic test_abort();
    int n_x;
    int dn;
    int bz;
    n_x = 0; dn = 0; bz = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h200; word_count = 16'd6; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 30 && n_x < 2; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (out_valid && out_ready) n_x++;
    end
    checks++;
    if (n_x !== 2) begin
      errors++;
      $display("FAIL abort_two_beats: got %0d required 2", n_x);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (outs_vec() !== 100'h0) begin
      errors++;
      $display("FAIL abort_outputs: got %h required 0", outs_vec());
    end
`ifdef IMEM_RB_CHECKSUM_EN
    checks++;
    if (checksum !== 32'h0) begin
      errors++;
      $display("FAIL abort_checksum: got %h required 0", checksum);
    end
`endif
    repeat (2) begin
      @(negedge clk); #1;
      if (done) dn++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (done) dn++;
      if (busy || out_valid || mem_rd_en) bz++;
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses required 0", dn);
    end
    checks++;
    if (bz !== 0) begin
      errors++;
      $display("FAIL abort_idle: got %0d active cycles required 0", bz);
    end
    run_xfer(32'h300, 16'd3, 0);
    checks++;
    if (got_addr.size() != 3) begin
      errors++;
      $display("FAIL abort_restart_beats: got %0d required 3", got_addr.size());
    end
    for (int i = 0; i < got_addr.size() && i < 3; i++) begin
      checks++;
      if (got_addr[i] !== exp_addr(32'h300, i) || got_data[i] !== mem_word(exp_addr(32'h300, i))) begin
        errors++;
        $display("FAIL abort_restart_beat%0d: got a=%h d=%h required a=%h d=%h", i, got_addr[i], got_data[i],
                 exp_addr(32'h300, i), mem_word(exp_addr(32'h300, i)));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] b;
    int          n;
    int          bad;
    for (int t = 0; t < 5; t++) begin
      b = $urandom;
      n = $urandom_range(1, 12);
      bad = 0;
      run_xfer(b, 16'(n), 2);
      checks++;
      if (got_addr.size() != n) begin
        errors++;
        $display("FAIL rand%0d_beats: got %0d required %0d", t, got_addr.size(), n);
      end
      for (int i = 0; i < got_addr.size() && i < n; i++) begin
        if (got_addr[i] !== exp_addr(b, i) || got_data[i] !== mem_word(exp_addr(b, i)) || got_last[i] !== (i == n - 1))
          bad++;
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL rand%0d_payload: got %0d wrong beats required 0", t, bad);
      end
      checks++;
      if (max_occ > 2 || stall_err !== 0) begin
        errors++;
        $display("FAIL rand%0d_flow: got occ=%0d unstable=%0d required <=2/0", t, max_occ, stall_err);
      end
      checks++;
      if (done_cnt !== 1) begin
        errors++;
        $display("FAIL rand%0d_done: got %0d pulses required 1", t, done_cnt);
      end
`ifdef IMEM_RB_CHECKSUM_EN
      checks++;
      if (cs_at_done !== exp_xor(b, n)) begin
        errors++;
        $display("FAIL rand%0d_checksum: got %h required %h", t, cs_at_done, exp_xor(b, n));
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_toggle_ready();
    test_wrap();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
